// File: rtl/sign_ext_if.sv
// Immediate-extension bus: raw immediate and mode in, combinational and registered
// extended values out.
interface sign_ext_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
);
    logic [IN_W-1:0]  data;
    logic [1:0]       ext_mode;
    logic             load;
    logic [OUT_W-1:0] outdata;
    logic [OUT_W-1:0] imm_out;
    logic [OUT_W-1:0] outdata_q;
    logic [OUT_W-1:0] imm_q;
    logic             valid_q;

    modport master (
        output data, ext_mode, load,
        input  outdata, imm_out, outdata_q, imm_q, valid_q
    );

    modport slave (
        input  data, ext_mode, load,
        output outdata, imm_out, outdata_q, imm_q, valid_q
    );
endinterface

// File: rtl/sign_ext.sv
// MIPS immediate-extension unit: combinational sign extension, a mode-selected
// immediate (sign/zero/LUI/word offset), and a load-enabled registered copy of both.
module sign_ext #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    sign_ext_if.slave   bus
);
    localparam int unsigned EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext_c;
    logic [OUT_W-1:0] imm_c;

    // Sign extension never touches clock or reset so it stays valid during reset.
    assign sext_c = {{EXT_W{bus.data[IN_W-1]}}, bus.data};

    always_comb begin
        imm_c = sext_c;
        case (bus.ext_mode)
            2'b00:   imm_c = sext_c;
            2'b01:   imm_c = {{EXT_W{1'b0}}, bus.data};
            2'b10:   imm_c = {bus.data, {EXT_W{1'b0}}};
            2'b11:   imm_c = {sext_c[OUT_W-3:0], 2'b00};
            default: imm_c = sext_c;
        endcase
    end

    assign bus.outdata = sext_c;
    assign bus.imm_out = imm_c;

    // Capture register; valid sticks high once loaded until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.outdata_q <= '0;
            bus.imm_q     <= '0;
            bus.valid_q   <= 1'b0;
        end else if (bus.load) begin
            bus.outdata_q <= sext_c;
            bus.imm_q     <= imm_c;
            bus.valid_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sign_ext.sv
// Self-checking bench for sign_ext: directed boundary vectors, random mode sweeps
// against an arithmetic reference model, and registered-path / async-reset checks.
module tb_sign_ext;
    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 32;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    sign_ext_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    sign_ext #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 if (clk_run) clk = ~clk;

    // Two's-complement value of the immediate as a plain integer.
    function automatic longint sval(input logic [15:0] d);
        longint v;
        v = longint'(d);
        if (d >= 16'h8000) v = v - 65536;
        return v;
    endfunction

    function automatic logic [31:0] model_sext(input logic [15:0] d);
        return 32'(sval(d));
    endfunction

    function automatic logic [31:0] model_imm(input logic [15:0] d, input logic [1:0] m);
        case (m)
            2'd0:    return 32'(sval(d));
            2'd1:    return 32'(longint'(d));
            2'd2:    return 32'(longint'(d) * 65536);
            default: return 32'(sval(d) * 4);
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.load = 1'b0;
        bus.ext_mode = 2'b00;
        bus.data = 16'hFFFF;
        #1;
        vectors++;
        if (bus.outdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_outdata: got %h want ffffffff", bus.outdata);
        end
        vectors++;
        if (bus.outdata_q !== 32'h0 || bus.imm_q !== 32'h0 || bus.valid_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got %h %h %b want 0 0 0", bus.outdata_q, bus.imm_q, bus.valid_q);
        end
    endtask

    task automatic test_sext_directed();
        logic [15:0] din [6]  = '{16'h8880, 16'h777F, 16'h8000, 16'h7FFF, 16'h0000, 16'h0001};
        logic [31:0] dexp [6] = '{32'hFFFF_8880, 32'h0000_777F, 32'hFFFF_8000,
                                  32'h0000_7FFF, 32'h0000_0000, 32'h0000_0001};
        for (int i = 0; i < 6; i++) begin
            bus.data = din[i];
            #1;
            vectors++;
            if (bus.outdata !== dexp[i]) begin
                errors++;
                $display("FAIL sext_directed[%0d]: data %h got %h want %h", i, din[i], bus.outdata, dexp[i]);
            end
        end
    endtask

    task automatic test_modes();
        logic [31:0] mexp [4] = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000, 32'hFFFE_0004};
        logic [15:0] d;
        logic [1:0]  m;
        bus.data = 16'h8001;
        for (int i = 0; i < 4; i++) begin
            bus.ext_mode = 2'(i);
            #1;
            vectors++;
            if (bus.imm_out !== mexp[i]) begin
                errors++;
                $display("FAIL mode_sweep[%0d]: got %h want %h", i, bus.imm_out, mexp[i]);
            end
            vectors++;
            if (bus.outdata !== 32'hFFFF_8001) begin
                errors++;
                $display("FAIL mode_indep[%0d]: got %h want ffff8001", i, bus.outdata);
            end
        end
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            m = 2'($urandom_range(0, 3));
            bus.data = d;
            bus.ext_mode = m;
            #1;
            vectors++;
            if (bus.outdata !== model_sext(d) || bus.imm_out !== model_imm(d, m)) begin
                errors++;
                $display("FAIL mode_random: data %h mode %0d got %h/%h want %h/%h",
                         d, m, bus.outdata, bus.imm_out, model_sext(d), model_imm(d, m));
            end
        end
    endtask

    task automatic test_load();
        clk_run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.load = 1'b1;
        bus.data = 16'h1234;
        bus.ext_mode = 2'b10;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.outdata_q !== 32'h0000_1234 || bus.imm_q !== 32'h1234_0000 || bus.valid_q !== 1'b1) begin
            errors++;
            $display("FAIL load_capture: got %h %h %b want 00001234 12340000 1",
                     bus.outdata_q, bus.imm_q, bus.valid_q);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        bus.load = 1'b0;
        bus.data = 16'hABCD;
        bus.ext_mode = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.outdata_q !== 32'h0000_1234 || bus.imm_q !== 32'h1234_0000 || bus.valid_q !== 1'b1) begin
            errors++;
            $display("FAIL hold: got %h %h %b want 00001234 12340000 1",
                     bus.outdata_q, bus.imm_q, bus.valid_q);
        end
        vectors++;
        if (bus.outdata !== 32'hFFFF_ABCD || bus.imm_out !== 32'hFFFE_AF34) begin
            errors++;
            $display("FAIL hold_comb: got %h %h want ffffabcd fffeaf34", bus.outdata, bus.imm_out);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.data = 16'h5A5A;
        #1;
        vectors++;
        if (bus.outdata_q !== 32'h0 || bus.imm_q !== 32'h0 || bus.valid_q !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: got %h %h %b want 0 0 0", bus.outdata_q, bus.imm_q, bus.valid_q);
        end
        vectors++;
        if (bus.outdata !== 32'h0000_5A5A) begin
            errors++;
            $display("FAIL reset_track: got %h want 00005a5a", bus.outdata);
        end
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.valid_q !== 1'b0 || bus.outdata_q !== 32'h0) begin
            errors++;
            $display("FAIL load_in_reset: got %h %b want 0 0", bus.outdata_q, bus.valid_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.load = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.valid_q !== 1'b0) begin
            errors++;
            $display("FAIL valid_after_release: got %b want 0", bus.valid_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_o = 32'h0;
        logic [31:0] exp_i = 32'h0;
        logic        exp_v = 1'b0;
        logic [15:0] d;
        logic [1:0]  m;
        logic        ld;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            d  = 16'($urandom);
            m  = 2'($urandom_range(0, 3));
            ld = 1'($urandom_range(0, 1));
            bus.data = d;
            bus.ext_mode = m;
            bus.load = ld;
            if (ld) begin
                exp_o = model_sext(d);
                exp_i = model_imm(d, m);
                exp_v = 1'b1;
            end
            @(posedge clk);
            #1;
            vectors++;
            if (bus.outdata_q !== exp_o || bus.imm_q !== exp_i || bus.valid_q !== exp_v) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h %h %b want %h %h %b",
                         i, bus.outdata_q, bus.imm_q, bus.valid_q, exp_o, exp_i, exp_v);
            end
        end
        bus.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sext_directed();
        test_modes();
        test_load();
        test_hold();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sign_ext.md
# sign_ext

Immediate-extension unit for the single-cycle MIPS datapath. It takes the 16-bit instruction immediate and always produces a combinational 32-bit sign-extended value on `outdata`, which feeds the ALU B-mux and branch-offset adder. It also provides a mode-selected immediate (sign, zero, upper-load, branch word offset) and a registered copy of both results for pipelined or multi-cycle reuse. The combinational path never depends on the clock or reset.

## Interface
Parameters:
- `IN_W`, 16, immediate width.
- `OUT_W`, 32, extended width; must satisfy `OUT_W >= IN_W + 2`.

Ports:
- `clk`  input  1  single clock; all registered state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `data`  input  IN_W  raw immediate field, instruction bits [15:0].
- `outdata`  output  OUT_W  combinational sign extension of `data`.
- `ext_mode`  input  2  selects `imm_out`: 00 sign, 01 zero, 10 upper (LUI), 11 sign-extended word offset (<<2).
- `imm_out`  output  OUT_W  combinational mode-selected immediate.
- `load`  input  1  capture enable for the registered outputs.
- `outdata_q`  output  OUT_W  registered `outdata`.
- `imm_q`  output  OUT_W  registered `imm_out`.
- `valid_q`  output  1  high when the registered outputs hold captured data.

## Operation
- `outdata = {{(OUT_W-IN_W){data[IN_W-1]}}, data}`: upper bits are copies of `data[15]`, lower 16 bits pass through unchanged.
- `outdata` is independent of `ext_mode`, `load`, `clk` and `rst_n`; it stays valid during reset.
- `imm_out` by `ext_mode`:
  - 00: same value as `outdata`.
  - 01: `{16'h0000, data}`, for ANDI/ORI/XORI.
  - 10: `{data, 16'h0000}`, for LUI.
  - 11: `outdata` shifted left 2 with zero fill into bits [1:0]; the top two sign bits are discarded.
- X/Z on `data` propagates to the outputs; the block performs no masking.
- Registered path: when `load=1` at a rising `clk`, `outdata_q <= outdata`, `imm_q <= imm_out`, `valid_q <= 1`.
- When `load=0`, all registered outputs hold. `valid_q` stays high until reset.
- Reset (`rst_n=0`): `outdata_q`, `imm_q` and `valid_q` go to 0 immediately without waiting for a clock edge, and stay at 0 while `rst_n` is low. `load` is ignored during reset.

## Timing
- `outdata` and `imm_out` are purely combinational with zero cycle latency. They must settle within one delta or propagation period of a change on `data` or `ext_mode`.
- Registered outputs have one-cycle latency: they reflect the inputs sampled at the `load` edge.
- Reset assertion mid-operation clears the registers asynchronously. On deassertion, the first rising edge with `load=1` captures data.
- Reset deassertion is synchronized upstream; this block requires no internal synchronizer.
- If `data` changes on the same edge that `load` samples, the register captures the pre-edge value.

## Test plan
- No clock, `data=16'hFFFF` -> `outdata=32'hFFFF_FFFF` after settling.
- `data=16'h8880` -> `outdata=32'hFFFF_8880`.
- `data=16'h777F` -> `outdata=32'h0000_777F`.
- Boundaries: `data=16'h8000` -> `outdata=32'hFFFF_8000`, and `16'h7FFF` -> `outdata=32'h0000_7FFF`.
- Mode sweep with `data=16'h8001`:
  - `ext_mode=00` -> `imm_out=32'hFFFF_8001`.
  - `ext_mode=01` -> `imm_out=32'h0000_8001`.
  - `ext_mode=10` -> `imm_out=32'h8001_0000`.
  - `ext_mode=11` -> `imm_out=32'hFFFE_0004`.
- Registered path:
  - Hold `rst_n=0` -> all `_q` outputs are 0.
  - Release reset, then apply `load=1`, `data=16'h1234`, `ext_mode=10` on one edge -> next cycle `outdata_q=32'h0000_1234`, `imm_q=32'h1234_0000`, `valid_q=1`.
  - Apply `load=0` with a new `data` -> registered outputs hold.
  - Drop `rst_n` between clock edges -> all `_q` outputs clear immediately, while `outdata` still tracks `data`.
